// File: rtl/memory_port_arbiter_if.sv
// Bus bundle for memory_port_arbiter: writer client, reader client, memory port and stats.
// slave = arbiter side, master = clients/memory side.
interface memory_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              wr_write_enable;
  logic              wr_ready;

  logic [ADDR_W-1:0] rd_address;
  logic              rd_read_enable;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_rdata;

  logic [15:0]       stat_wr_cnt;
  logic [15:0]       stat_rd_cnt;

  modport slave (
    input  wr_address, wr_data, wr_write_enable,
    input  rd_address, rd_read_enable,
    input  mem_rdata,
    output wr_ready, rd_ready, rd_data, rd_valid,
    output mem_address, mem_data, mem_write_enable, mem_read_enable,
    output stat_wr_cnt, stat_rd_cnt
  );

  modport master (
    output wr_address, wr_data, wr_write_enable,
    output rd_address, rd_read_enable,
    output mem_rdata,
    input  wr_ready, rd_ready, rd_data, rd_valid,
    input  mem_address, mem_data, mem_write_enable, mem_read_enable,
    input  stat_wr_cnt, stat_rd_cnt
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a writer and a reader, with burst cap,
// registered memory side and read-return pipeline. Optional transfer counters: ARB_STATS_EN.
module memory_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic                  clk,
  input logic                  rst,
  memory_port_arbiter_if.slave bus
);

  localparam int unsigned BURST_W = 4;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_OWN = 2'd1,
    S_RD_OWN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_rd;
  logic [BURST_W-1:0]   r_burst;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic [BURST_W-1:0]   w_burst_inc;
  logic                 w_wr_req;
  logic                 w_rd_req;
  logic                 w_grant_wr;
  logic                 w_grant_rd;

  logic [ADDR_W-1:0]    r_mem_address;
  logic [DATA_W-1:0]    r_mem_data;
  logic                 r_mem_we;
  logic                 r_mem_re;

  logic [RD_LATENCY-1:0] r_rd_pipe;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_rd_data;

  assign w_wr_req    = bus.wr_write_enable;
  assign w_rd_req    = bus.rd_read_enable;
  assign w_burst_inc = (r_burst == BURST_SAT) ? r_burst : r_burst + BURST_W'(1);

  // Arbitration: state records owner of the last accepted transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_req && (!w_rd_req || r_last_rd)) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = S_WR_OWN;
          w_burst_nxt = BURST_W'(1);
        end else if (w_rd_req) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = S_RD_OWN;
          w_burst_nxt = BURST_W'(1);
        end
      end
      S_WR_OWN: begin
        if (w_wr_req && ((r_burst < BURST_MAX) || !w_rd_req)) begin
          w_grant_wr  = 1'b1;
          w_burst_nxt = w_burst_inc;
        end else if (w_rd_req) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = S_RD_OWN;
          w_burst_nxt = BURST_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_burst_nxt = '0;
        end
      end
      S_RD_OWN: begin
        if (w_rd_req && ((r_burst < BURST_MAX) || !w_wr_req)) begin
          w_grant_rd  = 1'b1;
          w_burst_nxt = w_burst_inc;
        end else if (w_wr_req) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = S_WR_OWN;
          w_burst_nxt = BURST_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_rd <= 1'b1;
      r_burst   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      if (w_grant_wr) begin
        r_last_rd <= 1'b0;
      end else if (w_grant_rd) begin
        r_last_rd <= 1'b1;
      end
    end
  end

  // Readies are held low for the whole reset, even though the FSM already sits in IDLE.
  assign bus.wr_ready = w_grant_wr & ~rst;
  assign bus.rd_ready = w_grant_rd & ~rst;

  // Memory side: one-cycle enables, address/data hold between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
    end else begin
      r_mem_we <= w_grant_wr;
      r_mem_re <= w_grant_rd;
      if (w_grant_wr) begin
        r_mem_address <= bus.wr_address;
        r_mem_data    <= bus.wr_data;
      end else if (w_grant_rd) begin
        r_mem_address <= bus.rd_address;
      end
    end
  end

  assign bus.mem_address      = r_mem_address;
  assign bus.mem_data         = r_mem_data;
  assign bus.mem_write_enable = r_mem_we;
  assign bus.mem_read_enable  = r_mem_re;

  // Read-return pipeline: the tap marks the cycle mem_rdata belongs to an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pipe  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pipe[0] <= w_grant_rd;
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        r_rd_pipe[k] <= r_rd_pipe[k-1];
      end
      r_rd_valid <= r_rd_pipe[RD_LATENCY-1];
      if (r_rd_pipe[RD_LATENCY-1]) begin
        r_rd_data <= bus.mem_rdata;
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_rd;

  // Saturating accepted-transfer counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_grant_wr && (r_stat_wr != 16'hFFFF)) begin
        r_stat_wr <= r_stat_wr + 16'd1;
      end
      if (w_grant_rd && (r_stat_rd != 16'hFFFF)) begin
        r_stat_rd <= r_stat_rd + 16'd1;
      end
    end
  end

  assign bus.stat_wr_cnt = r_stat_wr;
  assign bus.stat_rd_cnt = r_stat_rd;
`else
  assign bus.stat_wr_cnt = 16'd0;
  assign bus.stat_rd_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: grant tables, scoreboarded memory side and read
// returns, reset with reads in flight, optional stats.
module tb_memory_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT    = 2;
  localparam int unsigned MAXB   = 4;
  localparam logic [31:0] KEY    = 32'hA5A5A5A5;
  localparam int          NVEC   = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory model for LAT=2: data for the read address shows up one cycle after mem_read_enable.
  logic [31:0] mem_addr_d;
  always @(posedge clk) mem_addr_d <= bus.mem_address;
  assign bus.mem_rdata = mem_addr_d ^ KEY;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  mem_op_t memq[$];
  rd_exp_t rdq[$];

  // Scoreboard monitor: expectations queued at accept, compared when the DUT should respond.
  always @(negedge clk) begin : mon
    mem_op_t op;
    rd_exp_t re;
    logic    exp_we;
    logic    exp_re;
    logic    exp_valid;
    if (!rst) begin
      exp_we = 1'b0;
      exp_re = 1'b0;
      chk("one_ready", 64'(bus.wr_ready & bus.rd_ready), 64'd0);
      if (memq.size() != 0 && memq[0].due == cyc) begin
        op     = memq.pop_front();
        exp_we = op.is_wr;
        exp_re = !op.is_wr;
        chk("mem_address", 64'(bus.mem_address), 64'(op.addr));
        if (op.is_wr) chk("mem_data", 64'(bus.mem_data), 64'(op.data));
      end
      chk("mem_write_enable", 64'(bus.mem_write_enable), 64'(exp_we));
      chk("mem_read_enable", 64'(bus.mem_read_enable), 64'(exp_re));
      exp_valid = (rdq.size() != 0) && (rdq[0].due == cyc);
      chk("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
      if (exp_valid) begin
        re = rdq.pop_front();
        chk("rd_data", 64'(bus.rd_data), 64'(re.data));
      end
      if (bus.wr_write_enable && bus.wr_ready)
        memq.push_back('{cyc + 1, 1'b1, bus.wr_address, bus.wr_data});
      if (bus.rd_read_enable && bus.rd_ready) begin
        memq.push_back('{cyc + 1, 1'b0, bus.rd_address, 32'h0});
        rdq.push_back('{cyc + 1 + int'(LAT), bus.rd_address ^ KEY});
      end
    end
  end

  typedef struct {
    logic wr;
    logic rd;
    logic exp_w;
    logic exp_r;
  } vec_t;

  vec_t tbl[NVEC];

  task automatic clear_reqs();
    bus.wr_write_enable = 1'b0;
    bus.rd_read_enable  = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    clear_reqs();
    rst = 1'b1;
    memq.delete();
    rdq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.wr_address = a;
    bus.wr_data = d;
    bus.wr_write_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wr_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.wr_write_enable = 1'b0;
  endtask

  task automatic rd_txn(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.rd_address = a;
    bus.rd_read_enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rd_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.rd_read_enable = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd0);
    chk({tag, "_rd_ready"}, 64'(bus.rd_ready), 64'd0);
    chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
    chk({tag, "_mem_address"}, 64'(bus.mem_address), 64'd0);
    chk({tag, "_mem_data"}, 64'(bus.mem_data), 64'd0);
    chk({tag, "_mem_we"}, 64'(bus.mem_write_enable), 64'd0);
    chk({tag, "_mem_re"}, 64'(bus.mem_read_enable), 64'd0);
  endtask

  initial begin
    int  acc;
    logic got;
    // Grant sequence from reset (last=RD, MAX_BURST=4).
    for (int i = 0; i < 4; i++) tbl[i]     = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 4; i < 8; i++) tbl[i]     = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 16; i < 21; i++) tbl[i]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b1};

    bus.wr_address = '0;
    bus.wr_data = '0;
    bus.rd_address = '0;
    bus.wr_write_enable = 1'b1;
    bus.rd_read_enable = 1'b1;

    // Reset state, readies forced low despite pending requests.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stat_wr", 64'(bus.stat_wr_cnt), 64'd0);
    chk("reset_stat_rd", 64'(bus.stat_rd_cnt), 64'd0);
    clear_reqs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Writer only: three back-to-back writes.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.wr_address = 32'h10 + 32'(4 * i);
      bus.wr_data = 32'hD000_0000 + 32'(i);
      bus.wr_write_enable = 1'b1;
      @(negedge clk);
      chk("t1_wr_ready", 64'(bus.wr_ready), 64'd1);
    end
    @(posedge clk); #1;
    clear_reqs();
    repeat (4) @(posedge clk);

    // Reader only: back-to-back reads of 0x0 and 0x4.
    #1;
    bus.rd_address = 32'h0;
    bus.rd_read_enable = 1'b1;
    @(negedge clk);
    chk("t2_rd_ready0", 64'(bus.rd_ready), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    bus.rd_address = 32'h4;
    @(negedge clk);
    chk("t2_rd_ready1", 64'(bus.rd_ready), 64'd1);
    @(posedge clk); #1;
    clear_reqs();
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("t2_rd_valid_seen", 64'(got), 64'd1);
    chk("t2_latency", 64'(cyc - acc), 64'(LAT + 1));
    chk("t2_rd_data0", 64'(bus.rd_data), 64'h0000_0000_A5A5_A5A5);
    @(negedge clk);
    chk("t2_rd_valid1", 64'(bus.rd_valid), 64'd1);
    chk("t2_rd_data1", 64'(bus.rd_data), 64'h0000_0000_A5A5_A5A1);
    repeat (3) @(posedge clk);

    // Grant table: bursts, tie-breaks, burst cap with idle opponent.
    apply_reset();
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      bus.wr_address = 32'h100 + 32'(4 * i);
      bus.wr_data = 32'hC0DE_0000 + 32'(i);
      bus.rd_address = 32'h200 + 32'(4 * i);
      bus.wr_write_enable = tbl[i].wr;
      bus.rd_read_enable = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_wr_ready", i), 64'(bus.wr_ready), 64'(tbl[i].exp_w));
      chk($sformatf("vec%0d_rd_ready", i), 64'(bus.rd_ready), 64'(tbl[i].exp_r));
    end
    @(posedge clk); #1;
    clear_reqs();
    repeat (5) @(posedge clk);

    // Reset with reads in flight after a write was served last.
    #1;
    bus.rd_address = 32'h40;
    bus.rd_read_enable = 1'b1;
    @(negedge clk);
    chk("t5_rd_ready0", 64'(bus.rd_ready), 64'd1);
    @(posedge clk); #1;
    bus.rd_address = 32'h44;
    @(negedge clk);
    chk("t5_rd_ready1", 64'(bus.rd_ready), 64'd1);
    @(posedge clk); #1;
    bus.rd_read_enable = 1'b0;
    bus.wr_address = 32'h50;
    bus.wr_data = 32'h5555_0000;
    bus.wr_write_enable = 1'b1;
    @(negedge clk);
    chk("t5_wr_ready", 64'(bus.wr_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    memq.delete();
    rdq.delete();
    bus.rd_read_enable = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_tie_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("t5_tie_rd_ready", 64'(bus.rd_ready), 64'd0);
    @(posedge clk); #1;
    clear_reqs();
    repeat (8) @(posedge clk);

    // Transfer counters.
    apply_reset();
    for (int i = 0; i < 5; i++) wr_txn(32'h300 + 32'(4 * i), 32'hBEEF_0000 + 32'(i));
    for (int i = 0; i < 3; i++) rd_txn(32'h400 + 32'(4 * i));
    repeat (6) @(posedge clk);
    #1;
`ifdef ARB_STATS_EN
    chk("stat_wr_cnt", 64'(bus.stat_wr_cnt), 64'd5);
    chk("stat_rd_cnt", 64'(bus.stat_rd_cnt), 64'd3);
    bus.wr_address = 32'h500;
    bus.wr_data = 32'h1234_5678;
    bus.wr_write_enable = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    clear_reqs();
    repeat (3) @(posedge clk);
    #1;
    chk("stat_wr_sat", 64'(bus.stat_wr_cnt), 64'hFFFF);
    chk("stat_rd_hold", 64'(bus.stat_rd_cnt), 64'd3);
`else
    chk("stat_wr_off", 64'(bus.stat_wr_cnt), 64'd0);
    chk("stat_rd_off", 64'(bus.stat_rd_cnt), 64'd0);
`endif

    repeat (6) @(posedge clk);
    chk("scoreboard_drained", 64'(memq.size() + rdq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
